branch_unit: RTL

- Registered, parametrised branch stage between decode and fetch/execute.
- Per accepted instruction it:
  - flags whether it is a branch;
  - evaluates the ARM condition field against NZCV;
  - computes the sign-extended, shifted, PC-relative target and the BL link value;
  - on a taken branch, drives a multi-cycle fetch flush.
- Valid/ready handshake on both sides; one-cycle latency.

---
 rtl/branch_unit_if.sv | 34 +++
 rtl/branch_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/branch_unit_if.sv
// Decode-side and fetch/execute-side handshake bundle for the branch stage.
// The stage sits on the slave side; the producer/consumer pair sits on the master side.
interface branch_unit_if #(
  parameter int unsigned FULLW     = 32,
  parameter int unsigned OP_TYPE_W = 3,
  parameter int unsigned IMM_W     = 24
);
  logic                 in_valid;
  logic                 in_ready;
  logic [OP_TYPE_W-1:0] optype;
  logic                 link;
  logic [3:0]           cond;
  logic [3:0]           flags;
  logic [FULLW-1:0]     pc;
  logic [IMM_W-1:0]     branch_imm;
  logic                 out_valid;
  logic                 out_ready;
  logic                 is_branch;
  logic                 taken;
  logic [FULLW-1:0]     target;
  logic                 link_we;
  logic [FULLW-1:0]     link_val;
  logic                 flush;

  modport master (
    output in_valid, optype, link, cond, flags, pc, branch_imm, out_ready,
    input  in_ready, out_valid, is_branch, taken, target, link_we, link_val, flush
  );

  modport slave (
    input  in_valid, optype, link, cond, flags, pc, branch_imm, out_ready,
    output in_ready, out_valid, is_branch, taken, target, link_we, link_val, flush
  );
endinterface

// File: rtl/branch_unit.sv
// Registered branch stage: ARM condition check, PC-relative target and BL link value,
// plus a fixed-length fetch flush after every taken branch.
module branch_unit #(
  parameter int unsigned          FULLW        = 32,
  parameter int unsigned          OP_TYPE_W    = 3,
  parameter logic [OP_TYPE_W-1:0] OP_BRANCH    = 3'd2,
  parameter int unsigned          IMM_W        = 24,
  parameter int unsigned          SHIFT        = 2,
  parameter int unsigned          PC_OFFSET    = 8,
  parameter int unsigned          LINK_OFFSET  = 4,
  parameter int unsigned          FLUSH_CYCLES = 2
) (
  input logic        clk,
  input logic        reset,
  branch_unit_if.slave bus
);

  localparam int unsigned      CNT_W    = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic             cond_pass;
  logic             accept;
  logic             ready_int;
  logic             flush_int;
  logic             is_branch_d;
  logic             taken_d;
  logic [FULLW-1:0] ext;
  logic [FULLW-1:0] target_d;
  logic [FULLW-1:0] link_val_d;

  logic             out_valid_q;
  logic             is_branch_q;
  logic             taken_q;
  logic             link_we_q;
  logic [FULLW-1:0] target_q;
  logic [FULLW-1:0] link_val_q;

  // Full sign extension then shift equals extending to FULLW-SHIFT and appending zeros.
  assign ext        = {{(FULLW-IMM_W){bus.branch_imm[IMM_W-1]}}, bus.branch_imm} << SHIFT;
  assign target_d   = bus.pc + FULLW'(PC_OFFSET) + ext;
  assign link_val_d = bus.pc + FULLW'(LINK_OFFSET);

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = bus.flags;
    cond_pass    = 1'b0;
    case (bus.cond)
      4'd0:    cond_pass = z;
      4'd1:    cond_pass = !z;
      4'd2:    cond_pass = c;
      4'd3:    cond_pass = !c;
      4'd4:    cond_pass = n;
      4'd5:    cond_pass = !n;
      4'd6:    cond_pass = v;
      4'd7:    cond_pass = !v;
      4'd8:    cond_pass = c && !z;
      4'd9:    cond_pass = !c || z;
      4'd10:   cond_pass = (n == v);
      4'd11:   cond_pass = (n != v);
      4'd12:   cond_pass = !z && (n == v);
      4'd13:   cond_pass = z || (n != v);
      4'd14:   cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign is_branch_d = (bus.optype == OP_BRANCH);
  assign taken_d     = is_branch_d && cond_pass;
  assign accept      = bus.in_valid && ready_int;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      RUN: begin
        if (accept && taken_d && (FLUSH_CYCLES > 0)) begin
          state_d = FLUSH;
          cnt_d   = CNT_LOAD;
        end
      end
      FLUSH: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    flush_int = (state == FLUSH);
    ready_int = (state == RUN) && (!out_valid_q || bus.out_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      is_branch_q <= 1'b0;
      taken_q     <= 1'b0;
      link_we_q   <= 1'b0;
      target_q    <= '0;
      link_val_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      is_branch_q <= is_branch_d;
      taken_q     <= taken_d;
      link_we_q   <= taken_d && bus.link;
      target_q    <= target_d;
      link_val_q  <= link_val_d;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready_int;
  assign bus.flush     = flush_int;
  assign bus.out_valid = out_valid_q;
  assign bus.is_branch = is_branch_q;
  assign bus.taken     = taken_q;
  assign bus.link_we   = link_we_q;
  assign bus.target    = target_q;
  assign bus.link_val  = link_val_q;

endmodule
